// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - control unit to datapath signal bundle
interface mc_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       op;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_src;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  op, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_src, illegal, state, retired
    );

    modport slave (
        output op, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_src, illegal, state, retired
    );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle CPU control FSM with retired-instruction counter
module mc_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_if.master     bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_AEX    = 4'd9,
        S_AWB    = 4'd10,
        S_JMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d           = state_q;
        retire            = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_src        = 2'b00;
        bus.illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                // IR and PC only load once the fetch data is actually there
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_REX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_AEX;
                    OP_J:         state_d = S_JMP;
                    default: begin
                        bus.illegal = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                retire         = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_REX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = S_RWB;
            end
            S_RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQ: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_src        = 2'b01;
                retire            = 1'b1;
                state_d           = S_FETCH;
            end
            S_AEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = S_AWB;
            end
            S_AWB: begin
                bus.reg_write = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 2'b10;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign bus.state   = state_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed self-checking bench for mc_ctrl
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mc_ctrl_if #(.CNT_W(16)) bus ();
    mc_ctrl_if #(.CNT_W(4))  bus2 ();

    mc_ctrl #(.CNT_W(16)) dut  (.clk(clk), .rst(rst),  .bus(bus));
    mc_ctrl #(.CNT_W(4))  dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src}
    localparam logic [15:0] V_FSTALL = 16'h1010;
    localparam logic [15:0] V_FRDY   = 16'h9410;
    localparam logic [15:0] V_DEC    = 16'h0030;
    localparam logic [15:0] V_MEMADR = 16'h0060;
    localparam logic [15:0] V_MEMRD  = 16'h3000;
    localparam logic [15:0] V_MEMWB  = 16'h0280;
    localparam logic [15:0] V_MEMWR  = 16'h2800;
    localparam logic [15:0] V_REX    = 16'h0048;
    localparam logic [15:0] V_RWB    = 16'h0180;
    localparam logic [15:0] V_BEQ    = 16'h4045;
    localparam logic [15:0] V_AEX    = 16'h0060;
    localparam logic [15:0] V_AWB    = 16'h0080;
    localparam logic [15:0] V_JMP    = 16'h8002;

    logic [15:0] vec;
    assign vec = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                  bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                  bus.pc_src};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // drive inputs for one cycle, check the combinational view, then clock
    task automatic cyc(input string tag, input logic [5:0] o, input logic r,
                       input logic [3:0] s, input logic [15:0] v, input logic il);
        bus.op        = o;
        bus.mem_ready = r;
        #1;
        chk({tag, ".state"}, 32'(bus.state), 32'(s));
        chk({tag, ".ctrl"}, 32'(vec), 32'(v));
        chk({tag, ".illegal"}, 32'(bus.illegal), 32'(il));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        bus.op         = 6'd0;
        bus.mem_ready  = 1'b0;
        bus2.op        = 6'd0;
        bus2.mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset.retired", 32'(bus.retired), 32'd0);
        cyc("reset", 6'd0, 1'b0, 4'd0, V_FSTALL, 1'b0);

        // R-type
        cyc("r.f",   6'b000000, 1'b1, 4'd0, V_FRDY, 1'b0);
        cyc("r.d",   6'b000000, 1'b1, 4'd1, V_DEC,  1'b0);
        cyc("r.ex",  6'b000000, 1'b1, 4'd6, V_REX,  1'b0);
        cyc("r.wb",  6'b000000, 1'b1, 4'd7, V_RWB,  1'b0);
        chk("r.retired", 32'(bus.retired), 32'd1);

        // lw with 2 fetch stalls and 3 read stalls; op wobbles in FETCH
        cyc("lw.fs0", 6'b111111, 1'b0, 4'd0, V_FSTALL, 1'b0);
        cyc("lw.fs1", 6'b000100, 1'b0, 4'd0, V_FSTALL, 1'b0);
        cyc("lw.f",   6'b100011, 1'b1, 4'd0, V_FRDY,   1'b0);
        cyc("lw.d",   6'b100011, 1'b1, 4'd1, V_DEC,    1'b0);
        cyc("lw.adr", 6'b100011, 1'b1, 4'd2, V_MEMADR, 1'b0);
        cyc("lw.rs0", 6'b101011, 1'b0, 4'd3, V_MEMRD,  1'b0);
        cyc("lw.rs1", 6'b101011, 1'b0, 4'd3, V_MEMRD,  1'b0);
        cyc("lw.rs2", 6'b101011, 1'b0, 4'd3, V_MEMRD,  1'b0);
        cyc("lw.rd",  6'b101011, 1'b1, 4'd3, V_MEMRD,  1'b0);
        cyc("lw.wb",  6'b101011, 1'b1, 4'd4, V_MEMWB,  1'b0);
        chk("lw.retired", 32'(bus.retired), 32'd2);

        // sw, beq, j, addi back to back
        cyc("sw.f",   6'b101011, 1'b1, 4'd0, V_FRDY,   1'b0);
        cyc("sw.d",   6'b101011, 1'b1, 4'd1, V_DEC,    1'b0);
        cyc("sw.adr", 6'b101011, 1'b1, 4'd2, V_MEMADR, 1'b0);
        cyc("sw.wr",  6'b100011, 1'b1, 4'd5, V_MEMWR,  1'b0);
        cyc("beq.f",  6'b000100, 1'b1, 4'd0, V_FRDY,   1'b0);
        cyc("beq.d",  6'b000100, 1'b1, 4'd1, V_DEC,    1'b0);
        cyc("beq.ex", 6'b000100, 1'b1, 4'd8, V_BEQ,    1'b0);
        cyc("j.f",    6'b000010, 1'b1, 4'd0, V_FRDY,   1'b0);
        cyc("j.d",    6'b000010, 1'b1, 4'd1, V_DEC,    1'b0);
        cyc("j.ex",   6'b000010, 1'b1, 4'd11, V_JMP,   1'b0);
        cyc("ad.f",   6'b001000, 1'b1, 4'd0, V_FRDY,   1'b0);
        cyc("ad.d",   6'b001000, 1'b1, 4'd1, V_DEC,    1'b0);
        cyc("ad.ex",  6'b001000, 1'b0, 4'd9, V_AEX,    1'b0);
        cyc("ad.wb",  6'b001000, 1'b0, 4'd10, V_AWB,   1'b0);
        chk("mix.retired", 32'(bus.retired), 32'd6);

        // illegal opcode
        cyc("ill.f",  6'b111111, 1'b1, 4'd0, V_FRDY, 1'b0);
        cyc("ill.d",  6'b111111, 1'b1, 4'd1, V_DEC,  1'b1);
        cyc("ill.f2", 6'b111111, 1'b0, 4'd0, V_FSTALL, 1'b0);
        chk("ill.retired", 32'(bus.retired), 32'd6);

        // reset while stalled in MEMRD
        cyc("rs.f",   6'b100011, 1'b1, 4'd0, V_FRDY,   1'b0);
        cyc("rs.d",   6'b100011, 1'b1, 4'd1, V_DEC,    1'b0);
        cyc("rs.adr", 6'b100011, 1'b1, 4'd2, V_MEMADR, 1'b0);
        bus.mem_ready = 1'b0;
        #1;
        chk("rs.stall.state", 32'(bus.state), 32'd3);
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rs.retired", 32'(bus.retired), 32'd0);
        cyc("rs.after", 6'b100011, 1'b0, 4'd0, V_FSTALL, 1'b0);
        cyc("rs.after2", 6'b100011, 1'b0, 4'd0, V_FSTALL, 1'b0);

        // counter wrap on the narrow instance: 15 R-types, then one more
        rst2 = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("wrap.full", 32'(bus2.retired), 32'd15);
        chk("wrap.full.state", 32'(bus2.state), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("wrap.zero", 32'(bus2.retired), 32'd0);
        chk("wrap.zero.state", 32'(bus2.state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
